// File: rtl/alu_issue_queue.sv
// alu_issue_queue: DEPTH-entry show-ahead FIFO between decode/regfile and the
// combinational 128-bit ALU.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   flush           synchronous clear of all queued entries (beats a same-cycle push)
//   in_valid/ready  upstream handshake; in_ready = (level < DEPTH)
//   in_opcode       0=ADD 1=SUB 2=AND 3=OR 4=SNE 5=PASSB; >5 is accepted and discarded
//   in_input1/2     operands, in_shift shift amount
//   alu_valid/ready downstream handshake, head presented from mem[rptr]
//   opcode, input1, input2, shiftValue  head entry, all zero when empty
//   level           occupancy 0..DEPTH
//   drop_pulse      one-cycle registered pulse after an illegal opcode is discarded
//
// Optional (macro ALU_ISSUE_STATS_EN):
//   issued_cnt[31:0]  saturating count of pops
//   dropped_cnt[15:0] saturating count of illegal-opcode discards
//   Both clear on rst only.
module alu_issue_queue #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_opcode,
  input  logic [WIDTH-1:0]         in_input1,
  input  logic [WIDTH-1:0]         in_input2,
  input  logic [4:0]               in_shift,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  output logic [3:0]               opcode,
  output logic [WIDTH-1:0]         input1,
  output logic [WIDTH-1:0]         input2,
  output logic [4:0]               shiftValue,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     drop_pulse
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]              issued_cnt,
  output logic [15:0]              dropped_cnt
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLevel = LW'(DEPTH);

  logic [3:0]       mem_op [DEPTH];
  logic [WIDTH-1:0] mem_a  [DEPTH];
  logic [WIDTH-1:0] mem_b  [DEPTH];
  logic [4:0]       mem_sh [DEPTH];

  logic [PW-1:0] wptr_q, rptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          drop_q;
  logic          accept, legal, push, pop, drop;

  always_comb begin
    in_ready  = (level_q != FullLevel);
    alu_valid = (level_q != '0);
    accept    = in_valid && in_ready;
    legal     = (in_opcode <= 4'd5);
    // Flush discards whatever arrives in the same cycle, legal or not.
    push      = accept && legal && !flush;
    drop      = accept && !legal && !flush;
    pop       = alu_valid && alu_ready;
  end

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= 1'b0;
    end else if (flush) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      level_q <= level_d;
      drop_q  <= drop;
    end
  end

  // Storage needs no reset: empty slots are never presented.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_op[wptr_q] <= in_opcode;
      mem_a[wptr_q]  <= in_input1;
      mem_b[wptr_q]  <= in_input2;
      mem_sh[wptr_q] <= in_shift;
    end
  end

  always_comb begin
    opcode     = '0;
    input1     = '0;
    input2     = '0;
    shiftValue = '0;
    if (alu_valid) begin
      opcode     = mem_op[rptr_q];
      input1     = mem_a[rptr_q];
      input2     = mem_b[rptr_q];
      shiftValue = mem_sh[rptr_q];
    end
  end

  assign level      = level_q;
  assign drop_pulse = drop_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] issued_q;
  logic [15:0] dropped_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q  <= '0;
      dropped_q <= '0;
    end else begin
      if (pop && (issued_q != '1))   issued_q  <= issued_q + 32'd1;
      if (drop && (dropped_q != '1)) dropped_q <= dropped_q + 16'd1;
    end
  end

  assign issued_cnt  = issued_q;
  assign dropped_cnt = dropped_q;
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue: expected ops are queued when pushed and
// compared against the ALU-side outputs when popped.
module tb_alu_issue_queue;

  localparam int unsigned WIDTH = 128;
  localparam int unsigned DEPTH = 4;

  typedef struct packed {
    logic [3:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       sh;
  } op_t;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, alu_ready;
  logic             in_ready, alu_valid, drop_pulse;
  logic [3:0]       in_opcode, opcode;
  logic [WIDTH-1:0] in_input1, in_input2, input1, input2;
  logic [4:0]       in_shift, shiftValue;
  logic [2:0]       level;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0]      issued_cnt;
  logic [15:0]      dropped_cnt;
`endif

  int total = 0;
  int bad   = 0;

  op_t sb[$];
  logic exp_drop;
  int   exp_issued, exp_dropped;

  alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_input1  (in_input1),
    .in_input2  (in_input2),
    .in_shift   (in_shift),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .opcode     (opcode),
    .input1     (input1),
    .input2     (input2),
    .shiftValue (shiftValue),
    .level      (level),
    .drop_pulse (drop_pulse)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .issued_cnt (issued_cnt),
    .dropped_cnt(dropped_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got,
                          input logic [WIDTH-1:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [4:0] sh);
    in_valid  = v;
    in_opcode = op;
    in_input1 = a;
    in_input2 = b;
    in_shift  = sh;
  endtask

  task automatic drive_rand(input logic [3:0] op);
    drive(1'b1, op, {$urandom, $urandom, $urandom, $urandom},
          {$urandom, $urandom, $urandom, $urandom}, 5'($urandom_range(31)));
  endtask

  // One clock: check status against the model, score pops, advance the model.
  task automatic cycle();
    logic m_ready, m_valid, do_push, do_pop, do_drop;
    op_t  head, incoming;
    #1;
    m_ready = (sb.size() < DEPTH);
    m_valid = (sb.size() != 0);
    check_eq("level", WIDTH'(level), WIDTH'(sb.size()));
    check_eq("alu_valid", WIDTH'(alu_valid), WIDTH'(m_valid));
    check_eq("in_ready", WIDTH'(in_ready), WIDTH'(m_ready));
    check_eq("drop_pulse", WIDTH'(drop_pulse), WIDTH'(exp_drop));
`ifdef ALU_ISSUE_STATS_EN
    check_eq("issued_cnt", WIDTH'(issued_cnt), WIDTH'(exp_issued));
    check_eq("dropped_cnt", WIDTH'(dropped_cnt), WIDTH'(exp_dropped));
`endif
    do_push = in_valid && m_ready && (in_opcode <= 4'd5) && !flush;
    do_drop = in_valid && m_ready && (in_opcode > 4'd5) && !flush;
    do_pop  = m_valid && alu_ready;
    if (do_pop) begin
      head = sb[0];
      check_eq("pop_opcode", WIDTH'(opcode), WIDTH'(head.op));
      check_eq("pop_input1", input1, head.a);
      check_eq("pop_input2", input2, head.b);
      check_eq("pop_shift", WIDTH'(shiftValue), WIDTH'(head.sh));
    end
    incoming = '{op: in_opcode, a: in_input1, b: in_input2, sh: in_shift};
    @(posedge clk);
    #1;
    if (do_pop) begin
      void'(sb.pop_front());
      exp_issued++;
    end
    if (flush) sb.delete();
    if (do_push) sb.push_back(incoming);
    if (do_drop) exp_dropped++;
    exp_drop = do_drop;
  endtask

  task automatic model_reset();
    sb.delete();
    exp_drop    = 1'b0;
    exp_issued  = 0;
    exp_dropped = 0;
  endtask

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    alu_ready = 1'b0;
    drive(1'b0, 4'd0, '0, '0, 5'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_level", WIDTH'(level), '0);
    check_eq("rst_alu_valid", WIDTH'(alu_valid), '0);
    check_eq("rst_opcode", WIDTH'(opcode), '0);
    check_eq("rst_input1", input1, '0);
    check_eq("rst_drop", WIDTH'(drop_pulse), '0);
    rst = 1'b0;

    // Single ADD, appears next cycle and holds while stalled.
    drive(1'b1, 4'd0, WIDTH'(5), WIDTH'(3), 5'd0);
    cycle();
    drive(1'b0, 4'd0, '0, '0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      check_eq("hold_opcode", WIDTH'(opcode), '0);
      check_eq("hold_input1", input1, WIDTH'(5));
      check_eq("hold_input2", input2, WIDTH'(3));
      check_eq("hold_level", WIDTH'(level), WIDTH'(1));
      cycle();
    end
    alu_ready = 1'b1;
    cycle();
    alu_ready = 1'b0;

    // Fill to DEPTH, stall a 5th push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive_rand((i == 3) ? 4'd5 : 4'(i));
      cycle();
    end
    drive_rand(4'd3);
    cycle();
    cycle();
    check_eq("full_level", WIDTH'(level), WIDTH'(4));
    check_eq("full_in_ready", WIDTH'(in_ready), '0);
    in_valid  = 1'b0;
    alu_ready = 1'b1;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
    check_eq("drained_level", WIDTH'(level), '0);
    check_eq("drained_valid", WIDTH'(alu_valid), '0);
    alu_ready = 1'b0;

    // Steady level=2 with push+pop every cycle across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive_rand(4'($urandom_range(5)));
      cycle();
    end
    alu_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_rand(4'($urandom_range(5)));
      cycle();
    end
    check_eq("steady_level", WIDTH'(level), WIDTH'(2));
    in_valid = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) cycle();
    alu_ready = 1'b0;

    // Illegal opcode: accepted, not stored, one-cycle drop pulse.
    drive_rand(4'd7);
    cycle();
    in_valid = 1'b0;
    check_eq("illegal_pulse", WIDTH'(drop_pulse), WIDTH'(1));
    check_eq("illegal_level", WIDTH'(level), '0);
    cycle();
    check_eq("illegal_pulse_end", WIDTH'(drop_pulse), '0);
`ifdef ALU_ISSUE_STATS_EN
    check_eq("illegal_dropped_cnt", WIDTH'(dropped_cnt), WIDTH'(1));
`endif

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) begin
      drive_rand(4'(i + 1));
      cycle();
    end
    drive_rand(4'd4);
    flush = 1'b1;
    cycle();
    flush    = 1'b0;
    in_valid = 1'b0;
    check_eq("flush_level", WIDTH'(level), '0);
    check_eq("flush_valid", WIDTH'(alu_valid), '0);
    check_eq("flush_opcode", WIDTH'(opcode), '0);
    check_eq("flush_input1", input1, '0);
    check_eq("flush_input2", input2, '0);
    check_eq("flush_shift", WIDTH'(shiftValue), '0);
    cycle();

    // Post-flush ordering, then asynchronous reset mid-cycle at level 3.
    for (int i = 0; i < 3; i++) begin
      drive_rand(4'(i));
      cycle();
    end
    in_valid = 1'b0;
    alu_ready = 1'b1;
    cycle();
    alu_ready = 1'b0;
    for (int i = 0; i < 1; i++) begin
      drive_rand(4'd5);
      cycle();
    end
    in_valid = 1'b0;
    check_eq("pre_rst_level", WIDTH'(level), WIDTH'(3));
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", WIDTH'(alu_valid), '0);
    check_eq("async_rst_level", WIDTH'(level), '0);
`ifdef ALU_ISSUE_STATS_EN
    check_eq("async_rst_issued", WIDTH'(issued_cnt), '0);
`endif
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
